// File: rtl/fifo_lifo_buf.sv
// Single-clock buffer that runs as a FIFO or a LIFO, selected while empty.
// Registered read: popped data and status appear one cycle after the request.
module fifo_lifo_buf #(
    parameter int dat_width = 32,
    parameter int adr_width = 6,
    parameter int mem_size  = 64
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 mode_i,
    input  logic                 push_i,
    input  logic [dat_width-1:0] dat_i,
    input  logic                 pop_i,
    output logic [dat_width-1:0] dat_o,
    output logic                 valid_o,
    output logic                 full_o,
    output logic                 empty_o,
    output logic [adr_width:0]   count_o,
    output logic                 overflow_o,
    output logic                 underflow_o
);
    localparam int CW = adr_width + 1;
    typedef logic [adr_width-1:0] ptr_t;
    typedef logic [CW-1:0]        cnt_t;
    localparam ptr_t LAST  = ptr_t'(mem_size - 1);
    localparam cnt_t DEPTH = cnt_t'(mem_size);

    logic [dat_width-1:0] mem_q [mem_size];

    logic [dat_width-1:0] dat_q, dat_d;
    ptr_t wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    cnt_t count_q, count_d;
    logic mode_q, mode_d;
    logic valid_q, valid_d, full_q, full_d, empty_q, empty_d;
    logic ovf_q, ovf_d, udf_q, udf_d;

    logic pop_acc, push_acc;
    ptr_t top_ptr, rd_addr, wr_addr;

    // Wrap on the depth, not on the pointer width, so non-power-of-2 depths work.
    function automatic ptr_t ptr_inc(input ptr_t p);
        return (p == LAST) ? '0 : p + ptr_t'(1);
    endfunction

    function automatic ptr_t ptr_dec(input ptr_t p);
        return (p == '0) ? LAST : p - ptr_t'(1);
    endfunction

    always_comb begin
        pop_acc  = pop_i && (count_q != '0);
        push_acc = push_i && ((count_q < DEPTH) || pop_acc);
        top_ptr  = ptr_dec(wr_ptr_q);
        rd_addr  = mode_q ? top_ptr : rd_ptr_q;
        // A LIFO push+pop replaces the top word in place.
        wr_addr  = (mode_q && pop_acc) ? top_ptr : wr_ptr_q;

        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        dat_d    = dat_q;

        if (mode_q) begin
            if (push_acc && !pop_acc)      wr_ptr_d = ptr_inc(wr_ptr_q);
            else if (pop_acc && !push_acc) wr_ptr_d = top_ptr;
        end else begin
            if (push_acc) wr_ptr_d = ptr_inc(wr_ptr_q);
            if (pop_acc)  rd_ptr_d = ptr_inc(rd_ptr_q);
        end

        if (push_acc && !pop_acc)      count_d = count_q + cnt_t'(1);
        else if (pop_acc && !push_acc) count_d = count_q - cnt_t'(1);

        if (pop_acc) dat_d = mem_q[rd_addr];

        mode_d  = (count_q == '0) ? mode_i : mode_q;
        valid_d = pop_acc;
        ovf_d   = push_i && !push_acc;
        udf_d   = pop_i && !pop_acc;
        full_d  = (count_d == DEPTH);
        empty_d = (count_d == '0);
    end

    always_ff @(posedge clk) begin
        if (push_acc) mem_q[wr_addr] <= dat_i;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            dat_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            mode_q   <= 1'b0;
            valid_q  <= 1'b0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
            ovf_q    <= 1'b0;
            udf_q    <= 1'b0;
        end else begin
            dat_q    <= dat_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            mode_q   <= mode_d;
            valid_q  <= valid_d;
            full_q   <= full_d;
            empty_q  <= empty_d;
            ovf_q    <= ovf_d;
            udf_q    <= udf_d;
        end
    end

    assign dat_o       = dat_q;
    assign valid_o     = valid_q;
    assign full_o      = full_q;
    assign empty_o     = empty_q;
    assign count_o     = count_q;
    assign overflow_o  = ovf_q;
    assign underflow_o = udf_q;
endmodule

// File: tb/tb_fifo_lifo_buf.sv
// Bench for fifo_lifo_buf: queue-based reference model compared every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_fifo_lifo_buf;
    localparam int DW = 32;
    localparam int AW = 6;
    localparam int MS = 64;

    logic          clk = 1'b0;
    logic          rst, mode_i, push_i, pop_i;
    logic [DW-1:0] dat_i, dat_o;
    logic          valid_o, full_o, empty_o, overflow_o, underflow_o;
    logic [AW:0]   count_o;

    fifo_lifo_buf #(.dat_width(DW), .adr_width(AW), .mem_size(MS)) dut (
        .clk(clk), .rst(rst), .mode_i(mode_i), .push_i(push_i), .dat_i(dat_i),
        .pop_i(pop_i), .dat_o(dat_o), .valid_o(valid_o), .full_o(full_o),
        .empty_o(empty_o), .count_o(count_o), .overflow_o(overflow_o),
        .underflow_o(underflow_o)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // Reference model: a queue of stored words, front = oldest, back = newest.
    logic [DW-1:0] q[$];
    bit            m_mode;
    logic [DW-1:0] e_dat;
    bit            e_vld, e_ovf, e_udf;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_step(input bit r, input bit m, input bit pu,
                              input logic [DW-1:0] d, input bit po);
        int  sz;
        bit  pop_ok, push_ok;
        sz = q.size();
        if (r) begin
            q.delete();
            m_mode = 1'b0;
            e_dat  = '0;
            e_vld  = 1'b0;
            e_ovf  = 1'b0;
            e_udf  = 1'b0;
            return;
        end
        pop_ok  = po && (sz > 0);
        push_ok = pu && ((sz < MS) || pop_ok);
        e_vld   = pop_ok;
        e_ovf   = pu && !push_ok;
        e_udf   = po && !pop_ok;
        if (pop_ok) e_dat = m_mode ? q[sz-1] : q[0];
        if (pop_ok && push_ok) begin
            if (m_mode) q[sz-1] = d;
            else begin
                void'(q.pop_front());
                q.push_back(d);
            end
        end else if (pop_ok) begin
            if (m_mode) void'(q.pop_back());
            else        void'(q.pop_front());
        end else if (push_ok) begin
            q.push_back(d);
        end
        if (sz == 0) m_mode = m;
    endtask

    task automatic compare_all();
        chk("dat_o",       {32'h0, dat_o}, {32'h0, e_dat});
        chk("valid_o",     64'(valid_o), 64'(e_vld));
        chk("overflow_o",  64'(overflow_o), 64'(e_ovf));
        chk("underflow_o", 64'(underflow_o), 64'(e_udf));
        chk("count_o",     64'(count_o), 64'(q.size()));
        chk("full_o",      64'(full_o), 64'(q.size() == MS));
        chk("empty_o",     64'(empty_o), 64'(q.size() == 0));
    endtask

    task automatic cyc(input bit r, input bit m, input bit pu,
                       input logic [DW-1:0] d, input bit po);
        rst = r; mode_i = m; push_i = pu; dat_i = d; pop_i = po;
        @(posedge clk);
        model_step(r, m, pu, d, po);
        #1;
        compare_all();
    endtask

    initial begin
        rst = 1'b1; mode_i = 1'b0; push_i = 1'b0; pop_i = 1'b0; dat_i = '0;
        cyc(1, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0);
        chk("reset_empty", 64'(empty_o), 64'd1);
        chk("reset_count", 64'(count_o), 64'd0);
        chk("reset_dat",   64'(dat_o), 64'd0);

        // FIFO order
        for (int i = 0; i < 4; i++) cyc(0, 0, 1, 32'h11 + 32'(i), 0);
        chk("fifo_count4", 64'(count_o), 64'd4);
        for (int i = 0; i < 4; i++) begin
            cyc(0, 0, 0, 0, 1);
            chk("fifo_pop_dat", 64'(dat_o), 64'h11 + 64'(i));
            chk("fifo_pop_vld", 64'(valid_o), 64'd1);
        end
        cyc(0, 0, 0, 0, 0);
        chk("fifo_vld_pulse", 64'(valid_o), 64'd0);
        chk("fifo_empty", 64'(empty_o), 64'd1);

        // LIFO order
        cyc(0, 1, 0, 0, 0);
        cyc(0, 1, 1, 32'hA, 0);
        cyc(0, 1, 1, 32'hB, 0);
        cyc(0, 1, 1, 32'hC, 0);
        for (int i = 0; i < 3; i++) begin
            cyc(0, 1, 0, 0, 1);
            chk("lifo_pop_dat", 64'(dat_o), 64'hC - 64'(i));
        end
        chk("lifo_empty", 64'(empty_o), 64'd1);

        // Full and overflow, rd_ptr wraps
        cyc(0, 0, 0, 0, 0);
        for (int i = 0; i < MS; i++) cyc(0, 0, 1, 32'(i), 0);
        chk("full_flag", 64'(full_o), 64'd1);
        chk("full_count", 64'(count_o), 64'd64);
        cyc(0, 0, 1, 32'hFF, 0);
        chk("ovf_pulse", 64'(overflow_o), 64'd1);
        chk("ovf_count", 64'(count_o), 64'd64);
        cyc(0, 0, 0, 0, 0);
        chk("ovf_clear", 64'(overflow_o), 64'd0);
        for (int i = 0; i < MS; i++) begin
            cyc(0, 0, 0, 0, 1);
            chk("full_drain_dat", 64'(dat_o), 64'(i));
        end

        // Underflow
        cyc(0, 0, 0, 0, 1);
        chk("udf_pulse", 64'(underflow_o), 64'd1);
        chk("udf_vld",   64'(valid_o), 64'd0);
        chk("udf_dat",   64'(dat_o), 64'd63);
        chk("udf_count", 64'(count_o), 64'd0);

        // Simultaneous push+pop, FIFO then LIFO
        cyc(0, 0, 1, 32'h5, 0);
        cyc(0, 0, 1, 32'h6, 0);
        cyc(0, 0, 1, 32'h7, 0);
        cyc(0, 0, 1, 32'h9, 1);
        chk("sim_fifo_dat", 64'(dat_o), 64'h5);
        chk("sim_fifo_cnt", 64'(count_o), 64'd3);
        for (int i = 0; i < 3; i++) cyc(0, 0, 0, 0, 1);
        chk("sim_fifo_last", 64'(dat_o), 64'h9);
        cyc(0, 1, 1, 32'hA, 0);
        cyc(0, 1, 1, 32'hB, 0);
        cyc(0, 1, 1, 32'h77, 1);
        chk("sim_lifo_dat", 64'(dat_o), 64'hB);
        cyc(0, 1, 0, 0, 1);
        chk("sim_lifo_top", 64'(dat_o), 64'h77);
        cyc(0, 1, 0, 0, 1);
        chk("sim_lifo_bot", 64'(dat_o), 64'hA);

        // Mode lock, then mid-stream reset
        cyc(0, 1, 1, 32'h21, 0);
        cyc(0, 1, 1, 32'h22, 0);
        cyc(0, 0, 0, 0, 1);
        chk("lock_pop1", 64'(dat_o), 64'h22);
        cyc(0, 0, 1, 32'h23, 0);
        cyc(0, 0, 1, 32'h24, 0);
        cyc(1, 1, 1, 32'h25, 1);
        chk("rst_count", 64'(count_o), 64'd0);
        chk("rst_empty", 64'(empty_o), 64'd1);
        cyc(0, 0, 1, 32'h31, 0);
        cyc(0, 0, 1, 32'h32, 0);
        cyc(0, 0, 0, 0, 1);
        chk("rst_fifo_mode", 64'(dat_o), 64'h31);
        cyc(0, 0, 0, 0, 1);

        // Randomized traffic with phases biased toward filling and draining
        for (int i = 0; i < 4000; i++) begin
            int ph;
            int pp;
            ph = (i / 250) % 4;
            pp = (ph == 0) ? 85 : (ph == 2) ? 15 : 50;
            cyc($urandom_range(0, 599) == 0, 1'($urandom),
                $urandom_range(0, 99) < pp, $urandom,
                $urandom_range(0, 99) < (100 - pp));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
